// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-masked writes, same-cycle write bypass
// and a per-register pending-write scoreboard used by decode for RAW stalls.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W/8-1:0]        wr_mask,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [2**ADDR_W-1:0]       busy_vec
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int NBYTES = DATA_W/8;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DATA_W-1:0] bit_mask;
  logic              wr_zero;
  logic              wr_store;

  for (genvar b = 0; b < NBYTES; b++) begin : g_mask
    assign bit_mask[b*8 +: 8] = {8{wr_mask[b]}};
  end

  assign wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_store = wr_en && !wr_zero;

  // NOTE: storage is flops rather than an SRAM macro because every register must
  // read back as zero straight after reset, so the whole array is reset here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_store) begin
      regs[wr_addr] <= (regs[wr_addr] & ~bit_mask) | (wr_data & bit_mask);
    end
  end

  // Clear before set: a reservation landing on a completing write is a new producer.
  // NOTE: combinational blocks use blocking '=' and assign a full default first,
  // so no path through the block leaves busy_nxt unassigned (no latch).
  always_comb begin
    busy_nxt = busy;
    if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] merged;
    logic              is_zero;
    logic              hit;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign stored  = regs[addr];
    assign merged  = (stored & ~bit_mask) | (wr_data & bit_mask);
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit     = (BYPASS != 0) && wr_en && (wr_addr == addr);

    // Reset also masks the bypass path so outputs stay quiet while reset is held.
    assign rd_data[k*DATA_W +: DATA_W] = (!reset || is_zero) ? '0 :
                                         hit ? merged : stored;
    assign rd_busy[k] = reset && busy[addr] && !hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: table-driven vectors through a scoreboard
// queue on the default and no-bypass builds, plus a 4-port narrow build.
module tb_regfile_mp;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, nb_rd_data;
  logic [NR-1:0]    rd_busy, nb_rd_busy;
  logic             wr_en, rsv_en;
  logic [AW-1:0]    wr_addr, rsv_addr;
  logic [DW/8-1:0]  wr_mask;
  logic [DW-1:0]    wr_data;
  logic [31:0]      busy_vec, nb_busy_vec;

  logic [11:0] s_rd_addr;
  logic [127:0] s_rd_data;
  logic [3:0]  s_rd_busy;
  logic        s_wr_en, s_rsv_en;
  logic [2:0]  s_wr_addr, s_rsv_addr;
  logic [3:0]  s_wr_mask;
  logic [31:0] s_wr_data;
  logic [7:0]  s_busy_vec;

  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(nb_busy_vec)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4)) dut_sw (
    .clk(clk), .reset(reset), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_mask(s_wr_mask), .wr_data(s_wr_data),
    .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr), .busy_vec(s_busy_vec)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  wa;
    logic [7:0]  wm;
    logic [63:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a0, a1;
    logic [63:0] e0, e1, enb;
    logic [1:0]  eb, enbb;
    logic [31:0] ebv;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] e0, e1, enb;
    logic [1:0]  eb, enbb;
    logic [31:0] ebv;
  } exp_t;

  vec_t vecs[16];
  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [4:0] wa,
                              input logic [7:0] wm, input logic [63:0] wd, input logic re,
                              input logic [4:0] ra, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] enb,
                              input logic [1:0] eb, input logic [1:0] enbb, input logic [31:0] ebv);
    vec_t v;
    v.name = name; v.we = we; v.wa = wa; v.wm = wm; v.wd = wd; v.re = re; v.ra = ra;
    v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1; v.enb = enb; v.eb = eb; v.enbb = enbb; v.ebv = ebv;
    return v;
  endfunction

  function automatic logic [31:0] sw_val(input int i);
    return (32'(i) + 32'd1) * 32'h0101_0101;
  endfunction

  initial begin
    exp_t e;
    logic [2:0] sa;

    // name, we, wa, wm, wd, re, ra, a0, a1, e0, e1, enb, eb, enbb, ebv
    vecs[0]  = mk("r3_full",   1, 3, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 3, 3,
                  64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 64'h0, 2'b00, 2'b00, 32'h0);
    vecs[1]  = mk("r3_lo",     1, 3, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 3, 3,
                  64'h1122_3344_AAAA_AAAA, 64'h1122_3344_AAAA_AAAA, 64'h1122_3344_5566_7788, 2'b00, 2'b00, 32'h0);
    vecs[2]  = mk("r3_next",   0, 0, 8'h00, 64'h0, 0, 0, 3, 3,
                  64'h1122_3344_AAAA_AAAA, 64'h1122_3344_AAAA_AAAA, 64'h1122_3344_AAAA_AAAA, 2'b00, 2'b00, 32'h0);
    vecs[3]  = mk("bypass_hi", 1, 3, 8'hF0, 64'hBBBB_BBBB_0000_0000, 0, 0, 3, 3,
                  64'hBBBB_BBBB_AAAA_AAAA, 64'hBBBB_BBBB_AAAA_AAAA, 64'h1122_3344_AAAA_AAAA, 2'b00, 2'b00, 32'h0);
    vecs[4]  = mk("r3_after",  0, 0, 8'h00, 64'h0, 0, 0, 3, 3,
                  64'hBBBB_BBBB_AAAA_AAAA, 64'hBBBB_BBBB_AAAA_AAAA, 64'hBBBB_BBBB_AAAA_AAAA, 2'b00, 2'b00, 32'h0);
    vecs[5]  = mk("zero_wr",   1, 0, 8'hFF, 64'h1234, 1, 0, 0, 0,
                  64'h0, 64'h0, 64'h0, 2'b00, 2'b00, 32'h0);
    vecs[6]  = mk("zero_after",0, 0, 8'h00, 64'h0, 0, 0, 0, 0,
                  64'h0, 64'h0, 64'h0, 2'b00, 2'b00, 32'h0);
    vecs[7]  = mk("rsv7",      0, 0, 8'h00, 64'h0, 1, 7, 7, 3,
                  64'h0, 64'hBBBB_BBBB_AAAA_AAAA, 64'h0, 2'b00, 2'b00, 32'h0);
    vecs[8]  = mk("r7_busy",   0, 0, 8'h00, 64'h0, 0, 0, 7, 7,
                  64'h0, 64'h0, 64'h0, 2'b11, 2'b11, 32'h80);
    vecs[9]  = mk("wr7",       1, 7, 8'hFF, 64'h7777_7777_7777_7777, 0, 0, 7, 7,
                  64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777, 64'h0, 2'b00, 2'b11, 32'h80);
    vecs[10] = mk("r7_clear",  0, 0, 8'h00, 64'h0, 0, 0, 7, 7,
                  64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777, 2'b00, 2'b00, 32'h0);
    vecs[11] = mk("rsv9",      0, 0, 8'h00, 64'h0, 1, 9, 9, 7,
                  64'h0, 64'h7777_7777_7777_7777, 64'h0, 2'b00, 2'b00, 32'h0);
    vecs[12] = mk("rsv_wr9",   1, 9, 8'h03, 64'h9999, 1, 9, 9, 9,
                  64'h9999, 64'h9999, 64'h0, 2'b00, 2'b11, 32'h200);
    vecs[13] = mk("r9_busy",   0, 0, 8'h00, 64'h0, 0, 0, 9, 9,
                  64'h9999, 64'h9999, 64'h9999, 2'b11, 2'b11, 32'h200);
    vecs[14] = mk("mask0",     1, 9, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 9, 9,
                  64'h9999, 64'h9999, 64'h9999, 2'b00, 2'b11, 32'h200);
    vecs[15] = mk("r9_free",   0, 0, 8'h00, 64'h0, 0, 0, 9, 9,
                  64'h9999, 64'h9999, 64'h9999, 2'b00, 2'b00, 32'h0);

    s_rd_addr = '0; s_wr_en = 0; s_wr_addr = '0; s_wr_mask = '0; s_wr_data = '0;
    s_rsv_en = 0; s_rsv_addr = '0;
    rsv_en = 0; rsv_addr = '0;

    // A write driven while reset is held must be dropped and not bypassed.
    reset = 1'b0;
    wr_en = 1; wr_addr = 5'd5; wr_mask = 8'hFF; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_addr = {5'd5, 5'd5};
    #12;
    check("rst_rd_data", rd_data[63:0], 64'h0);
    check("rst_rd_busy", 64'(rd_busy), 64'h0);
    check("rst_busy_vec", 64'(busy_vec), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    wr_en = 0; wr_mask = '0; wr_data = '0;
    #2;
    check("rst_r5", rd_data[63:0], 64'h0);
    check("rst_busy_vec_rel", 64'(busy_vec), 64'h0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_mask = vecs[i].wm; wr_data = vecs[i].wd;
      rsv_en = vecs[i].re; rsv_addr = vecs[i].ra;
      rd_addr = {vecs[i].a1, vecs[i].a0};
      e.name = vecs[i].name; e.e0 = vecs[i].e0; e.e1 = vecs[i].e1; e.enb = vecs[i].enb;
      e.eb = vecs[i].eb; e.enbb = vecs[i].enbb; e.ebv = vecs[i].ebv;
      sb_q.push_back(e);
      #2;
      e = sb_q.pop_front();
      check({e.name, ".rd0"},      rd_data[63:0],         e.e0);
      check({e.name, ".rd1"},      rd_data[127:64],       e.e1);
      check({e.name, ".busy"},     64'(rd_busy),          64'(e.eb));
      check({e.name, ".busy_vec"}, 64'(busy_vec),         64'(e.ebv));
      check({e.name, ".nb_rd0"},   nb_rd_data[63:0],      e.enb);
      check({e.name, ".nb_busy"},  64'(nb_rd_busy),       64'(e.enbb));
      check({e.name, ".nb_bvec"},  64'(nb_busy_vec),      64'(e.ebv));
    end
    @(negedge clk);
    wr_en = 0; rsv_en = 0;

    // Narrow 4-port build: fill all eight registers, then read them concurrently.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_wr_en = 1; s_wr_addr = 3'(i); s_wr_mask = 4'hF; s_wr_data = sw_val(i);
    end
    @(negedge clk);
    s_wr_en = 0;
    s_rd_addr = {3'd7, 3'd6, 3'd2, 3'd1};
    #2;
    for (int k = 0; k < 4; k++) begin
      sa = s_rd_addr[k*3 +: 3];
      check($sformatf("sweep_a.port%0d", k), 64'(s_rd_data[k*32 +: 32]), 64'(sw_val(int'(sa))));
    end
    check("sweep_a.busy", 64'(s_rd_busy), 64'h0);
    @(negedge clk);
    s_rd_addr = {3'd0, 3'd5, 3'd4, 3'd3};
    #2;
    for (int k = 0; k < 3; k++) begin
      sa = s_rd_addr[k*3 +: 3];
      check($sformatf("sweep_b.port%0d", k), 64'(s_rd_data[k*32 +: 32]), 64'(sw_val(int'(sa))));
    end
    check("sweep_b.r0", 64'(s_rd_data[127:96]), 64'h0);
    check("sweep_b.busy_vec", 64'(s_busy_vec), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file with per-byte write masking, same-cycle write-to-read bypass and a per-register pending-write scoreboard.
- Successor to the 32x64 two-read register file in the pipelined core. Sits between decode (reads, reservations) and writeback (writes).
- Scoreboard lets decode stall on RAW hazards without a separate hazard unit.

Parameters:
- DATA_W, 64, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy.
- BYPASS, 1, 1 = a same-cycle write is forwarded to read ports; 0 = reads return stored contents only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port k's register has an outstanding reservation.
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_W  write address.
- wr_mask  in  DATA_W/8  byte-lane write enables.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  reserve a register (mark pending).
- rsv_addr  in  ADDR_W  register to reserve.
- busy_vec  out  2**ADDR_W  registered scoreboard, bit i = register i pending.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers clear to 0 and all busy bits clear.
  - rd_data reads 0 and rd_busy reads 0 while reset is held.
  - busy_vec = 0.
  - Release is synchronous to the next posedge; there are no output registers beyond the state.
- Write, posedge with wr_en=1:
  - for each byte lane b with wr_mask[b]=1, reg[wr_addr][8b+7:8b] <= wr_data[8b+7:8b]; unmasked lanes hold their value.
  - wr_mask=0 is a legal no-op write, but it still clears busy.
  - ZERO_REG=1 with wr_addr=0: no state change.
- Read (combinational, all ports independent, any ports may share an address):
  - BYPASS=1, wr_en=1, rd_addr==wr_addr and not (ZERO_REG and addr=0): rd_data = masked merge (wr_data on enabled lanes, stored bytes elsewhere).
  - Otherwise rd_data = stored contents.
  - ZERO_REG=1 and addr=0: always 0.
- Scoreboard, posedge, evaluated in this order:
  - wr_en=1 clears busy[wr_addr].
  - rsv_en=1 sets busy[rsv_addr].
  - rsv_addr==wr_addr in the same cycle: the set wins (new producer), so busy = 1 next cycle.
  - Reserving an already-busy register keeps it busy (no count; one outstanding producer per register).
  - ZERO_REG=1: busy[0] is always 0.
- rd_busy[k] = busy[rd_addr_k] AND NOT (BYPASS AND wr_en AND wr_addr==rd_addr_k).
  - A completing write is seen as not busy in the same cycle, consistent with the bypassed data.
  - rsv_en does not affect rd_busy in the same cycle.
- Latency:
  - read: 0 cycles.
  - write visible through storage: 1 cycle; through bypass: 0 cycles.
  - reservation visible: 1 cycle.
- Reset asserted mid-operation: pending writes and reservations in that cycle are discarded.
- No X propagation: unused upper busy_vec bits do not exist (width exactly DEPTH).

Test Plan:
- Reset: hold reset=0, write 64'hFFFF_FFFF_FFFF_FFFF to r5 with wr_mask=8'hFF. Release, read r5 -> 0; busy_vec -> 0.
- Byte mask: write r3 = 64'h1122_3344_5566_7788 (mask FF). Then write 64'hAAAA_AAAA_AAAA_AAAA with mask 8'h0F. Next cycle r3 -> 64'h1122_3344_AAAA_AAAA.
- Bypass: with the cycle-2 r3 value from the byte-mask test, drive wr_en, wr_addr=3, mask 8'hF0, data 64'hBBBB_BBBB_0000_0000, with rd_addr0=rd_addr1=3. Same cycle both ports -> 64'hBBBB_BBBB_AAAA_AAAA.
  - Repeat with BYPASS=0 -> old value 64'h1122_3344_AAAA_AAAA.
- Zero register: write r0 = 64'h1234 and reserve r0. Read r0 -> 0, rd_busy=0, busy_vec[0]=0.
- Scoreboard:
  - rsv r7 -> next cycle busy_vec[7]=1 and rd_busy=1 for r7.
  - Write r7 -> rd_busy=0 in the write cycle; busy_vec[7]=0 after.
  - Simultaneous rsv r9 and wr r9 (r9 busy) -> busy_vec[9]=1 after the edge.
- Parameter sweep: NUM_RD=4, ADDR_W=3, DATA_W=32. Write distinct values to all 8 registers; 4 ports reading r1, r2, r6, r7 concurrently -> the matching values.
